bit_serializer: RTL
===================

# bit_serializer

Upstream feeder for the serial pattern detectors. It accepts parallel words over a valid/ready handshake and buffers them in a small FIFO. Each word is shifted out one bit per clock on the single-bit stream `x` that the detector samples every cycle. When no payload is available, a fixed idle level is driven so that idle time never forms a spurious pattern.

## Interface
- `DATA_W`, 8: payload word width; legal values 2..32.
- `FIFO_DEPTH`, 4: input buffer depth in words; power of two, at least 2.
- `IDLE_BIT`, 1'b1: level driven on `x` whenever no payload or parity bit is being sent.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst_n`  input  1  reset, synchronous and active-low.
- `in_data`  input  DATA_W  word to serialize.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  FIFO can accept a word.
- `msb_first`  input  1  bit order; 1 = MSB first. Sampled at word pop.
- `x`  output  1  serial bit stream; one bit per cycle.
- `x_valid`  output  1  `x` carries a payload or parity bit (not idle fill).
- `busy`  output  1  FIFO non-empty or a frame in flight.
- `frame_done`  output  1  one-cycle pulse after a frame's last bit.

## Operation
- Push: a word enters the FIFO on a rising edge where `in_valid && in_ready`.
  - `in_ready = (count < FIFO_DEPTH)`. No pass-through when full: a simultaneous push and pop at full is refused.
  - `in_ready` is forced to 0 while `rst_n` is low.
- FSM states: IDLE, SHIFT, and PARITY (PARITY exists only with the macro).
  - IDLE → SHIFT: FIFO non-empty. Pop the word, load the shift register, latch `msb_first`, and set the bit counter to `DATA_W-1`.
  - SHIFT: each cycle, drive the current bit and decrement the counter.
  - At counter 0, with parity disabled: if the FIFO is non-empty, pop the next word and stay in SHIFT (zero-gap back-to-back). Otherwise go to IDLE.
  - At counter 0, with parity enabled: go to PARITY.
  - PARITY: drive one parity bit. Then pop and go to SHIFT if the FIFO is non-empty, otherwise go to IDLE.
- Output `x`:
  - SHIFT: the selected shift-register bit.
  - PARITY: the parity bit.
  - IDLE: `IDLE_BIT`.
  - `x_valid` = 1 exactly in SHIFT and PARITY.
- `frame_done`: registered; high for the one cycle immediately after the cycle in which the frame's final bit was driven.
- `busy = (count != 0) || (state != IDLE)`.
- The counter width is `$clog2(DATA_W)`. The FIFO pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally. The count is one bit wider.
- Reset values:
  - state IDLE, FIFO empty, `x = IDLE_BIT`, `x_valid = 0`, `busy = 0`, `frame_done = 0`.
  - Shift register and counter are cleared to 0.
- Reset asserted mid-frame: the frame is aborted and all buffered words are discarded. On the edge where `rst_n` is sampled low, the state is forced to IDLE, and `x` shows `IDLE_BIT` from the following cycle. No `frame_done` pulse is produced for the aborted frame.
- A change of `msb_first` during a frame has no effect until the next pop.

## Timing
- Word accepted at edge E0 into an empty, idle block:
  - pop at edge E0+1;
  - first bit on `x` during cycle E0+1..E0+2;
  - last payload bit during cycle E0+DATA_W..E0+DATA_W+1.
- Back-to-back words: the next word's first bit immediately follows the previous frame's last bit (or its parity bit), with no idle cycle.
- Frame length: `DATA_W` cycles, or `DATA_W+1` with parity enabled.
- `in_ready` reflects the count after the previous edge. A pop frees a slot for the next cycle's push.

## Configuration
- Macro `BIT_SERIALIZER_PARITY_EN`.
- Defined: the PARITY state exists and one even-parity bit (`^word`) is appended after each payload. `x_valid` is high during the parity bit, and `frame_done` follows the parity bit.
- Undefined: the PARITY state and its logic are absent, and frames are exactly `DATA_W` bits.

## Structure
- Shared package `bit_serializer_pkg` holds:
  - the state enum `ser_state_t` {IDLE, SHIFT, PARITY};
  - default constants for `DATA_W`, `FIFO_DEPTH` and `IDLE_BIT`.
- One sub-module, `sync_fifo`:
  - parameterized width and depth;
  - `push`/`pop`/`full`/`empty`/`count` interface;
  - same clock and synchronous active-low reset.
- The FSM, shift register and output muxing live in the top module.

## Test plan
- Single word, parity off: push 8'hA5 with `msb_first = 1` at E0 → `x` = 1,0,1,0,0,1,0,1 over cycles E0+1..E0+9, `x_valid` high for exactly those 8 cycles, then `frame_done` for one cycle; `x = 1` before and after.
- LSB-first: push 8'h01 with `msb_first = 0` → `x` = 1,0,0,0,0,0,0,0.
- Back-to-back: push 8'hF0 then 8'h0F on consecutive edges → 16 contiguous `x_valid` cycles with bits 11110000 00001111, no idle gap, and one `frame_done` per frame.
- Backpressure: hold `in_valid` with 6 words while idle → `in_ready` drops after the FIFO fills (4 words; the first pop frees one slot). All 6 words are eventually emitted in order, none lost or duplicated.
- Reset mid-frame: assert `rst_n = 0` for one cycle after 3 bits of 8'hFF with 2 words queued → `x = 1`, `x_valid = 0` next cycle, `busy = 0`, no `frame_done`, and no queued words are ever emitted.
- With `BIT_SERIALIZER_PARITY_EN`: push 8'h07 → 8 payload bits then parity bit 1 (9 `x_valid` cycles); push 8'h03 → parity bit 0.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// Shared types and default constants for the bit_serializer block.
package bit_serializer_pkg;

    // Serializer FSM states; PARITY is only reachable when BIT_SERIALIZER_PARITY_EN is defined.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_t;

    localparam int unsigned DATA_W_DEF     = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam logic        IDLE_BIT_DEF   = 1'b1;

endpackage : bit_serializer_pkg

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset, count/full/empty status
// and a show-ahead read port (rdata is the head word while not empty).
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Guard the handshake so an overflow or underflow can never corrupt state.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    assign rdata = r_mem[r_rd_ptr];
    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wdata;
    end

endmodule : sync_fifo

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: buffers words in a FIFO and shifts each one out
// a bit per cycle on x, driving IDLE_BIT between frames.
// Optional feature macro: BIT_SERIALIZER_PARITY_EN appends an even-parity bit.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter logic        IDLE_BIT   = IDLE_BIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              msb_first,
    output logic              x,
    output logic              x_valid,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

    ser_state_t        r_state;
    ser_state_t        w_state_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_msb;
    logic              w_msb_nxt;
    logic              r_x;
    logic              w_x_nxt;
    logic              r_x_valid;
    logic              w_x_valid_nxt;
    logic              r_frame_done;
    logic              w_frame_done_nxt;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic              r_par;
    logic              w_par_nxt;
`endif

    logic              w_load;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_fifo_rdata;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [FCNT_W-1:0] w_fifo_count;

    // Refuse pushes at full (no pass-through) and while reset is held.
    assign in_ready = rst_n && !w_fifo_full;
    assign w_push   = in_valid && in_ready;

    assign x          = r_x;
    assign x_valid    = r_x_valid;
    assign frame_done = r_frame_done;
    assign busy       = (w_fifo_count != '0) || (r_state != IDLE);

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .wdata (in_data),
        .pop   (w_pop),
        .rdata (w_fifo_rdata),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    // State, datapath and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_msb        <= 1'b0;
            r_x          <= IDLE_BIT;
            r_x_valid    <= 1'b0;
            r_frame_done <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            r_par        <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_cnt        <= w_cnt_nxt;
            r_msb        <= w_msb_nxt;
            r_x          <= w_x_nxt;
            r_x_valid    <= w_x_valid_nxt;
            r_frame_done <= w_frame_done_nxt;
`ifdef BIT_SERIALIZER_PARITY_EN
            r_par        <= w_par_nxt;
`endif
        end
    end

    // Next-state logic; x/x_valid are precomputed from the next state so the
    // registered outputs line up with the state they describe.
    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_cnt_nxt        = r_cnt;
        w_msb_nxt        = r_msb;
        w_frame_done_nxt = 1'b0;
        w_load           = 1'b0;
        w_pop            = 1'b0;
        w_x_nxt          = IDLE_BIT;
        w_x_valid_nxt    = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
        w_par_nxt        = r_par;
`endif

        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) w_load = 1'b1;
            end
            SHIFT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                    w_shift_nxt = r_msb ? {r_shift[DATA_W-2:0], 1'b0}
                                        : {1'b0, r_shift[DATA_W-1:1]};
                end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_frame_done_nxt = 1'b1;
                    if (!w_fifo_empty) w_load = 1'b1;
                    else               w_state_nxt = IDLE;
`endif
                end
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            PARITY: begin
                w_frame_done_nxt = 1'b1;
                if (!w_fifo_empty) w_load = 1'b1;
                else               w_state_nxt = IDLE;
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Pop and load a new word; bit order is frozen here for the whole frame.
        if (w_load) begin
            w_pop       = 1'b1;
            w_state_nxt = SHIFT;
            w_shift_nxt = w_fifo_rdata;
            w_msb_nxt   = msb_first;
            w_cnt_nxt   = CNT_W'(DATA_W - 1);
`ifdef BIT_SERIALIZER_PARITY_EN
            w_par_nxt   = ^w_fifo_rdata;
`endif
        end

        case (w_state_nxt)
            SHIFT: begin
                w_x_valid_nxt = 1'b1;
                w_x_nxt       = w_msb_nxt ? w_shift_nxt[DATA_W-1] : w_shift_nxt[0];
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            PARITY: begin
                w_x_valid_nxt = 1'b1;
                w_x_nxt       = w_par_nxt;
            end
`endif
            default: begin
                w_x_valid_nxt = 1'b0;
                w_x_nxt       = IDLE_BIT;
            end
        endcase
    end

endmodule : bit_serializer
